// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width, read FSM states and saturating magnitude helper
package audio_pkg;
    localparam int SAMPLE_W = 24;
    typedef enum logic [1:0] {R_IDLE, R_POP, R_HOLD} rstate_t;
    function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
        return (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) ? {1'b0, {(SAMPLE_W-1){1'b1}}} :
               (s[SAMPLE_W-1] ? -s : s);
    endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word fall-through sample FIFO with occupancy count
module sample_fifo #(
    parameter int W = 24,
    parameter int DEPTH = 16
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      push,
    input  logic [W-1:0]              din,
    input  logic                      pop,
    output logic [W-1:0]              dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = empty ? '0 : mem[rp];
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mic_pitch_reader.sv
// mic_pitch_reader: pops codec samples, mixes to mono, buffers them and tracks pitch period and peak level
module mic_pitch_reader
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int FIFO_DEPTH = 16,
    parameter logic [SAMPLE_W-1:0] HYST = 'h400,
    parameter int MAX_PERIOD = 2048,
    parameter int LEVEL_WIN = 1024
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                enable,
    input  logic                audio_in_available,
    input  logic [31:0]         left_channel_audio_in,
    input  logic [31:0]         right_channel_audio_in,
    output logic                read_audio_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [15:0]         period_out,
    output logic                period_valid,
    output logic [SAMPLE_W-1:0] level_out,
    output logic                overflow
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(LEVEL_WIN);
    localparam logic signed [SAMPLE_W-1:0] HI = HYST;
    localparam logic signed [SAMPLE_W-1:0] LO = -HYST;
    rstate_t state, state_d;
    logic full, empty, cap, pop_go, armed, locked, rise;
    logic [CW:0] count;
    logic signed [31:0] mono;
    logic signed [SAMPLE_W-1:0] s;
    logic [SAMPLE_W-1:0] a, peak, run_max;
    logic [15:0] cnt, cnt_inc;
    logic [WW-1:0] wcnt;
    assign mono = ($signed(left_channel_audio_in) >>> 1) + ($signed(right_channel_audio_in) >>> 1);
    assign s = SAMPLE_W'(mono >>> (32 - SAMPLE_W));
    assign cap = state == R_POP;
    assign a = abs_sat(s);
    assign peak = (a > run_max) ? a : run_max;
    assign cnt_inc = (cnt == 16'(MAX_PERIOD)) ? cnt : cnt + 16'd1;
    assign rise = armed & (s >= HI);
    assign pop_go = enable & audio_in_available & (count < (CW+1)'(FIFO_DEPTH));
    assign sample_valid = ~empty;
    always_comb begin
        state_d = R_IDLE;
        state_d = (state == R_IDLE) ? (pop_go ? R_POP : R_IDLE) :
                  (state == R_POP) ? R_HOLD : R_IDLE;
    end
    sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .push(cap),
        .din(s),
        .pop(sample_ready),
        .dout(sample_out),
        .full(full),
        .empty(empty),
        .count(count)
    );
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= R_IDLE;
            read_audio_in <= 1'b0;
            overflow <= 1'b0;
            cnt <= '0;
            armed <= 1'b0;
            locked <= 1'b0;
            period_out <= '0;
            period_valid <= 1'b0;
            run_max <= '0;
            wcnt <= '0;
            level_out <= '0;
        end else begin
            state <= state_d;
            read_audio_in <= state_d == R_POP;
            period_valid <= 1'b0;
            if (state == R_IDLE && enable && audio_in_available && full) overflow <= 1'b1;
            if (cap) begin
                if (rise) begin
                    if (locked) begin
                        period_out <= cnt;
                        period_valid <= 1'b1;
                    end
                    cnt <= 16'd1;
                    armed <= 1'b0;
                    locked <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                    armed <= armed | (s < LO);
                    if (locked && cnt_inc == 16'(MAX_PERIOD)) begin
                        period_out <= '0;
                        period_valid <= 1'b1;
                        locked <= 1'b0;
                    end
                end
                if (wcnt == WW'(LEVEL_WIN - 1)) begin
                    level_out <= peak;
                    run_max <= '0;
                    wcnt <= '0;
                end else begin
                    run_max <= peak;
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mic_pitch_reader.sv
// tb_mic_pitch_reader: directed stimulus against a sample-level behavioural model of the mic reader
module tb_mic_pitch_reader;
    localparam int D = 16;
    localparam int MAXP = 2048;
    localparam int WIN = 1024;
    localparam int HYST = 1024;
    logic clk = 1'b0;
    logic reset = 1'b1, enable = 1'b0, avail = 1'b0, ready = 1'b0;
    logic [31:0] left, right;
    logic rd, svalid, pvalid, ovf;
    logic [23:0] sout, level;
    logic [15:0] period;
    int mode = 0;
    int src = 0;
    int errors = 0, checks = 0;
    logic [23:0] q[$];
    bit e_read, e_hold, e_ovf, e_pv, armed, locked;
    logic [15:0] e_period;
    logic [23:0] e_level;
    int n, last_x, run_max;
    int pulses = 0, zero_pulses = 0, reads = 0;

    always #5 clk = ~clk;

    mic_pitch_reader dut (
        .CLOCK_50(clk),
        .reset(reset),
        .enable(enable),
        .audio_in_available(avail),
        .left_channel_audio_in(left),
        .right_channel_audio_in(right),
        .read_audio_in(rd),
        .sample_out(sout),
        .sample_valid(svalid),
        .sample_ready(ready),
        .period_out(period),
        .period_valid(pvalid),
        .level_out(level),
        .overflow(ovf)
    );

    function automatic int gen(int md, int k);
        int sq = ((k / 25) % 2 == 0) ? 1048576 : -1048576;
        return md == 0 ? 4194304 : md == 1 ? sq : md == 2 ? (k < 200 ? sq : 0) :
               k == 500 ? -8388608 : k == 1023 ? 8384512 : k * 4096;
    endfunction

    always_comb begin
        left = 32'(gen(mode, src) * 256 + ((mode == 1 || mode == 2) ? 256 : 0));
        right = 32'(gen(mode, src) * 256 - ((mode == 1 || mode == 2) ? 256 : 0));
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit cur, nxt;
        int sz, l, r, s, a, wm;
        if (reset) begin
            q.delete();
            e_read = 0; e_hold = 0; e_ovf = 0; e_pv = 0;
            e_period = '0; e_level = '0;
            n = 0; last_x = 0; run_max = 0; armed = 0; locked = 0;
            src <= 0;
            return;
        end
        cur = e_read;
        sz = q.size();
        e_pv = 0;
        nxt = !cur && !e_hold && enable && avail && sz < D;
        if (!cur && !e_hold && enable && avail && sz == D) e_ovf = 1;
        if (sz > 0 && ready) void'(q.pop_front());
        if (cur) begin
            l = $signed(left);
            r = $signed(right);
            s = ((l >>> 1) + (r >>> 1)) >>> 8;
            q.push_back(24'(s));
            src <= src + 1;
            n++;
            if (armed && s >= HYST) begin
                if (locked) begin
                    e_period = 16'(n - last_x);
                    e_pv = 1;
                end
                locked = 1;
                last_x = n;
                armed = 0;
            end else if (locked && n - last_x + 1 >= MAXP) begin
                e_period = '0;
                e_pv = 1;
                locked = 0;
            end
            if (s < -HYST) armed = 1;
            a = s < 0 ? -s : s;
            if (a > 8388607) a = 8388607;
            wm = a > run_max ? a : run_max;
            if (n % WIN == 0) begin
                e_level = 24'(wm);
                run_max = 0;
            end else run_max = wm;
        end
        e_hold = cur;
        e_read = nxt;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("read", 32'(rd), 32'(e_read));
        chk("valid", 32'(svalid), 32'(q.size() > 0));
        chk("sample", 32'(sout), 32'(q.size() > 0 ? q[0] : 24'd0));
        chk("period", 32'(period), 32'(e_period));
        chk("pvalid", 32'(pvalid), 32'(e_pv));
        chk("level", 32'(level), 32'(e_level));
        chk("overflow", 32'(ovf), 32'(e_ovf));
        if (pvalid) begin
            pulses++;
            if (period == 16'd0) zero_pulses++;
        end
        if (rd) reads++;
    end

    task automatic cycles(int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        avail = 1'b0;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic run_until(int target, int budget, string nm);
        for (int i = 0; i < budget && src < target; i++) cycles(1);
        chk(nm, 32'(src >= target), 32'd1);
        avail = 1'b0;
        cycles(5);
    endtask

    initial begin
        int r0, p0, z0, s0;
        cycles(3);
        chk("reset_outputs", {rd, svalid, pvalid, ovf, 4'h0, sout}, 32'd0);
        chk("reset_level_period", {level, 8'h0} | 32'(period), 32'd0);
        do_reset();
        mode = 0; enable = 1'b1; avail = 1'b1; ready = 1'b1;
        cycles(9);
        r0 = reads;
        cycles(30);
        chk("t1_reads", 32'(reads - r0), 32'd10);
        for (int i = 0; i < 20 && !svalid; i++) cycles(1);
        chk("t1_sample", 32'(sout), 32'h400000);
        do_reset();
        ready = 1'b0; avail = 1'b1;
        cycles(80);
        chk("t2_pushed", 32'(src), 32'd16);
        chk("t2_overflow", 32'(ovf), 32'd1);
        chk("t2_read_stopped", 32'(rd), 32'd0);
        ready = 1'b1;
        cycles(20);
        chk("t2_ovf_sticky", 32'(ovf), 32'd1);
        do_reset();
        mode = 1; avail = 1'b1;
        p0 = pulses;
        run_until(400, 2000, "t3_budget");
        chk("t3_pulses", 32'(pulses - p0), 32'd6);
        chk("t3_period", 32'(period), 32'd50);
        do_reset();
        mode = 2; avail = 1'b1;
        p0 = pulses; z0 = zero_pulses;
        run_until(2300, 8000, "t4_budget");
        chk("t4_zero_pulses", 32'(zero_pulses - z0), 32'd1);
        chk("t4_pulses", 32'(pulses - p0), 32'd3);
        chk("t4_period", 32'(period), 32'd0);
        enable = 1'b0; avail = 1'b1; s0 = src;
        cycles(20);
        chk("en0_no_pop", 32'(src), 32'(s0));
        enable = 1'b1;
        do_reset();
        mode = 3; avail = 1'b1;
        run_until(1023, 4000, "t5_budget_a");
        chk("t5_level_pending", 32'(level), 32'd0);
        avail = 1'b1;
        run_until(1024, 100, "t5_budget_b");
        chk("t5_level", 32'(level), 32'h7FFFFF);
        do_reset();
        mode = 0; avail = 1'b1; ready = 1'b0;
        cycles(10);
        for (int i = 0; i < 20 && !rd; i++) cycles(1);
        chk("t6_rd_seen", 32'(rd), 32'd1);
        reset = 1'b1;
        cycles(1);
        chk("t6_outputs", {rd, svalid, pvalid, ovf, 4'h0, sout}, 32'd0);
        chk("t6_level_period", {level, 8'h0} | 32'(period), 32'd0);
        reset = 1'b0; avail = 1'b0;
        cycles(5);
        chk("t6_no_push", 32'(svalid), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
